pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage scalar+vector AES pipeline.
- Drives enable/flush/bubble controls of PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three conditions:
  - load-use hazards, split by scalar/vector register namespace;
  - multi-cycle S-box ops occupying EX, via a counter-driven FSM;
  - taken-branch flushes resolved in EX.

Parameters:
- SBOX_LAT, 4, cycles an S-box op occupies EX (legal 1..16)
- REG_W, 5, register index width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ID_rs1  in  REG_W  source 1 of instr in ID
- ID_rs2  in  REG_W  source 2 of instr in ID
- ID_rs_used  in  2  bit0: rs1 read, bit1: rs2 read
- ID_vec  in  1  ID sources are vector registers
- EX_rd  in  REG_W  destination of instr in EX
- EX_MemToReg  in  1  instr in EX is a load
- EX_RegWrite  in  1  EX writes scalar file
- EX_VRegWrite  in  1  EX writes vector file
- EX_sbox_start  in  1  instr in EX is an S-box op (held high while it sits in EX)
- EX_branch_taken  in  1  branch in EX resolved taken
- pc_en  out  1  PC load enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads bubble
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX loads bubble
- exmem_bubble  out  1  EX/MEM loads bubble
- sbox_busy  out  1  FSM in BUSY

Behaviour:
- Reset: while rst_n=0, async: state=RUN, cnt=0; pc_en=ifid_en=idex_en=0, ifid_flush=idex_flush=exmem_bubble=1, sbox_busy=0.
- Control outputs are combinational from state, cnt and inputs. They act in the same cycle the condition is present.
- Any flush/bubble overrides the matching enable.
- FSM states: RUN, BUSY. cnt is 4 bits.
- Load-use hazard (lu), all must hold:
  - EX_MemToReg=1;
  - an ID source is used and equal to EX_rd;
  - namespace match: (ID_vec=0 and EX_RegWrite=1 and EX_rd!=0) or (ID_vec=1 and EX_VRegWrite=1).
  - Vector reg 0 is a real register; scalar reg 0 never hazards.
- RUN, defaults: all enables 1, flushes 0, exmem_bubble 0.
- RUN, priority high to low:
  1. EX_sbox_start and SBOX_LAT>=2: pc_en=ifid_en=idex_en=0, exmem_bubble=1. Next state BUSY with cnt<=SBOX_LAT-2. Branch and lu are ignored this cycle.
  2. EX_branch_taken: pc_en=1, ifid_flush=1, idex_flush=1.
  3. lu: pc_en=ifid_en=0, idex_flush=1. This is a one-cycle bubble; the load leaves EX next cycle.
- SBOX_LAT=1: EX_sbox_start has no effect.
- BUSY, cnt!=0: same freeze as RUN item 1; cnt<=cnt-1. EX_sbox_start is ignored (still high from the same instr). EX_branch_taken and lu are ignored.
- BUSY, cnt==0: release cycle. Evaluate RUN items 2–3 (EX_sbox_start ignored); next state RUN.
- Total freeze per S-box op = SBOX_LAT-1 cycles. The op then advances on the release cycle.
- A back-to-back S-box op reaching EX after release is detected in RUN normally.
- sbox_busy=1 iff state==BUSY.
- EX_branch_taken together with lu: branch wins (the ID instr is discarded anyway).
- Reset asserted mid-BUSY: immediate return to RUN, cnt=0; no residual stall after rst_n rises.

Optional Feature:
- Macro: HAZ_STATS_EN
- When defined, add output stall_cycles (16 bits). It counts cycles with rst_n=1 and pc_en=0 and saturates at 16'hFFFF. Async reset to 0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Load x5 in EX (EX_RegWrite=1), ID reads rs1=5 scalar -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1.
- Load to x0 with ID rs1=0 scalar -> no stall. Vector load EX_rd=0, EX_VRegWrite=1, ID_vec=1 rs2=0 used -> stall. Scalar write x3, ID_vec=1 reads v3 -> no stall.
- SBOX_LAT=4, EX_sbox_start held high -> exactly 3 cycles with exmem_bubble=1 and pc_en=0; sbox_busy high cycles 2–4; cycle 4 is release with enables 1; state returns to RUN.
- EX_branch_taken=1 during BUSY cnt!=0 -> ignored; held until release cycle -> ifid_flush=idex_flush=1, pc_en=1 that cycle.
- EX_branch_taken=1 with lu -> ifid_flush=1, idex_flush=1, pc_en=1.
- rst_n pulsed low in BUSY cnt=2 -> outputs immediately at reset values; after release, EX_sbox_start=0 gives RUN defaults. With HAZ_STATS_EN, stall_cycles=0 after reset, then increments per stalled cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use, multi-cycle S-box and taken-branch control.
// Optional HAZ_STATS_EN adds stall_cycles, a saturating count of pc_en=0 cycles.
// Ports:
//   clk, rst_n               clock and async active-low reset
//   ID_rs1/ID_rs2/ID_rs_used/ID_vec           sources of the instr in ID
//   EX_rd/EX_MemToReg/EX_RegWrite/EX_VRegWrite destination and kind of the instr in EX
//   EX_sbox_start/EX_branch_taken             S-box op and taken branch in EX
//   pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble, sbox_busy
module pipe_hazard_ctrl #(
  parameter int SBOX_LAT = 4,
  parameter int REG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic [1:0]       ID_rs_used,
  input  logic             ID_vec,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             EX_MemToReg,
  input  logic             EX_RegWrite,
  input  logic             EX_VRegWrite,
  input  logic             EX_sbox_start,
  input  logic             EX_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             sbox_busy
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam bit       SBOX_ON  = (SBOX_LAT >= 2);
  localparam logic [3:0] CNT_INIT =
    SBOX_ON ? 4'(SBOX_LAT - 2) : 4'd0;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       lu, freeze;

  // Scalar x0 never hazards; vector v0 is a real register.
  always_comb begin
    lu = 1'b0;
    if (EX_MemToReg &&
        ((ID_rs_used[0] && ID_rs1 == EX_rd) ||
         (ID_rs_used[1] && ID_rs2 == EX_rd)))
      lu = ID_vec ? EX_VRegWrite
                  : (EX_RegWrite && EX_rd != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    freeze       = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;

    unique case (state)
      RUN: begin
        if (EX_sbox_start && SBOX_ON) begin
          freeze  = 1'b1;
          state_n = BUSY;
          cnt_n   = CNT_INIT;
        end
      end
      BUSY: begin
        // cnt==0 is the release cycle: op advances, branch/lu resolved.
        if (cnt != 4'd0) begin
          freeze = 1'b1;
          cnt_n  = cnt - 4'd1;
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = 4'd0;
      end
    endcase

    if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_bubble = 1'b1;
    end else if (EX_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end

    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_bubble = 1'b1;
    end
  end

  assign sbox_busy = (state == BUSY);

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= 16'd0;
    else if (!pc_en && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule
